// File: rtl/uart_program_loader.sv
// UART (8N1) program-image loader: writes a length-prefixed image into memory.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module uart_program_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  output logic              mem_write_enable,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    L_LEN_LO, L_LEN_HI, L_DATA, L_WRITE,
`ifdef LOADER_CHECKSUM_EN
    L_CHK,
`endif
    L_DONE, L_ERR
  } ld_state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam ld_state_t L_FIN = L_CHK;
`else
  localparam ld_state_t L_FIN = L_DONE;
`endif

  // rx_d is one cycle older than rx_s, giving a falling-edge detect
  logic rx_m, rx_s, rx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  rx_state_t      rx_st, rx_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [2:0]     bit_idx, bit_nx;
  logic [7:0]     shreg, sh_nx;
  logic           byte_valid, frame_err;

  always_comb begin
    rx_nx      = rx_st;
    cnt_nx     = cnt + 1'b1;
    bit_nx     = bit_idx;
    sh_nx      = shreg;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (rx_st)
      RX_IDLE: begin
        cnt_nx = '0;
        bit_nx = '0;
        if (rx_d && !rx_s) rx_nx = RX_START;
      end
      RX_START: begin
        if (cnt == HALF) begin
          cnt_nx = '0;
          rx_nx  = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == FULL) begin
          cnt_nx = '0;
          sh_nx  = {rx_s, shreg[7:1]};
          bit_nx = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == FULL) begin
          cnt_nx     = '0;
          rx_nx      = RX_IDLE;
          byte_valid = rx_s;
          frame_err  = !rx_s;
        end
      end
      default: rx_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rx_st   <= rx_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_nx;
      shreg   <= sh_nx;
    end
  end

  ld_state_t   st, st_nx;
  logic [15:0] len, len_nx;
  logic [15:0] wl_nx;
  logic [1:0]  bcnt, bcnt_nx;
  logic [31:0] word, word_nx;
  logic [31:0] data_nx;
  logic [15:0] n_full;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum, csum_nx;
`endif

  assign n_full = {shreg, len[7:0]};

  always_comb begin
    st_nx   = st;
    len_nx  = len;
    wl_nx   = words_loaded;
    bcnt_nx = bcnt;
    word_nx = word;
    data_nx = mem_data_in;
`ifdef LOADER_CHECKSUM_EN
    csum_nx = csum;
`endif
    unique case (st)
      L_LEN_LO: begin
        if (frame_err) st_nx = L_ERR;
        else if (byte_valid) begin
          len_nx = {8'h00, shreg};
          st_nx  = L_LEN_HI;
        end
      end
      L_LEN_HI: begin
        if (frame_err) st_nx = L_ERR;
        else if (byte_valid) begin
          len_nx = n_full;
          if (n_full > 16'(MAX_WORDS)) st_nx = L_ERR;
          else if (n_full == 16'd0)    st_nx = L_FIN;
          else                         st_nx = L_DATA;
        end
      end
      L_DATA: begin
        if (frame_err) st_nx = L_ERR;
        else if (byte_valid) begin
          // bytes shift in from the top so byte0 ends up in [7:0]
          word_nx = {shreg, word[31:8]};
          bcnt_nx = bcnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_nx = csum ^ shreg;
`endif
          if (bcnt == 2'd3) begin
            data_nx = {shreg, word[31:8]};
            st_nx   = L_WRITE;
          end
        end
      end
      L_WRITE: begin
        wl_nx = words_loaded + 16'd1;
        st_nx = (wl_nx == len) ? L_FIN : L_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      L_CHK: begin
        if (frame_err) st_nx = L_ERR;
        else if (byte_valid) st_nx = (shreg == csum) ? L_DONE : L_ERR;
      end
`endif
      L_DONE: st_nx = L_DONE;
      L_ERR:  st_nx = L_ERR;
      default: st_nx = L_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= L_LEN_LO;
      len          <= '0;
      words_loaded <= '0;
      bcnt         <= '0;
      word         <= '0;
      mem_data_in  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      st           <= st_nx;
      len          <= len_nx;
      words_loaded <= wl_nx;
      bcnt         <= bcnt_nx;
      word         <= word_nx;
      mem_data_in  <= data_nx;
`ifdef LOADER_CHECKSUM_EN
      csum         <= csum_nx;
`endif
    end
  end

  assign mem_address      = BASE_ADDR + ADDR_W'(words_loaded);
  assign mem_write_enable = (st == L_WRITE);
  assign cpu_hold         = (st != L_DONE);
  assign done             = (st == L_DONE);
  assign error            = (st == L_ERR);

endmodule
